voting_tally_seq: RTL and testbench
===================================

// Module: voting_tally_seq
// PURPOSE
// - Sequential, parametrised ballot tallier: NUM_CAND candidates, up to NUM_VOTERS ballots per round.
// - Ballots stream in one per cycle over a valid/ready handshake; per-candidate counters accumulate.
// - On close, an argmax scan reports winner, count, strict-majority flag and tie flag.
// - Replaces the fixed-size combinational vote circuits where voters arrive serially; used as a reusable voting stage.
// PARAMETERS
// - NUM_CAND    1  candidates (approval bits per ballot); 1 = yes/no referendum mode
// - NUM_VOTERS  4  max ballots per round; reaching it auto-closes the round
// - CNT_W  = $clog2(NUM_VOTERS+1)       derived count width
// - IDX_W  = max(1,$clog2(NUM_CAND))    derived index width
// PORTS
// - clk           in   1         single clock, rising edge
// - rst           in   1         synchronous, active-high reset
// - start         in   1         begin round (IDLE only)
// - ballot_valid  in   1         ballot present
// - ballot_ready  out  1         ballot accepted when valid&ready
// - ballot        in   NUM_CAND  approval vector; bit i = vote for candidate i
// - close         in   1         end round early (COLLECT only)
// - result_valid  out  1         result held until result_ready
// - result_ready  in   1         consumer accepts result
// - winner_idx    out  IDX_W     argmax candidate, lowest index on tie
// - winner_cnt    out  CNT_W     votes of winner
// - ballots_cnt   out  CNT_W     ballots accepted this round
// - majority      out  1         2*winner_cnt > ballots_cnt
// - tie           out  1         see BEHAVIOUR
// BEHAVIOUR
// - Reset: state IDLE; all counters, winner_idx, winner_cnt, ballots_cnt, majority, tie = 0; ballot_ready=0, result_valid=0.
// - FSM IDLE -> COLLECT on start; counters and ballots_cnt cleared on that edge.
// - COLLECT: ballot_ready=1; each handshake adds ballot[i] to cnt[i], ballots_cnt+1.
// - COLLECT -> DECIDE when close=1, or handshake makes ballots_cnt==NUM_VOTERS; ballot on same cycle as close is counted.
// - DECIDE: one candidate per cycle, i=0..NUM_CAND-1; replace best only if cnt[i] > best (strict => lowest index wins ties).
// - Latency: close/last ballot at edge t -> result_valid=1 from edge t+NUM_CAND+1.
// - DONE: result_valid=1, outputs stable; DONE -> IDLE when result_ready=1 (result_valid drops next cycle).
// - ballot_ready=0 outside COLLECT; ballot_valid there ignored, no count change.
// - start outside IDLE, close outside COLLECT: ignored.
// - tie: NUM_CAND>1 -> another candidate has cnt == winner_cnt; NUM_CAND==1 -> 2*winner_cnt == ballots_cnt.
// - Empty round (close with 0 ballots): winner_idx=0, winner_cnt=0, majority=0, tie=1.
// - Counters cannot overflow: bounded by NUM_VOTERS via auto-close; majority compare done at CNT_W+1 bits.
// - rst mid-round: abandons round, returns to reset state next edge.
// STRUCTURE
// - voting_pkg: state enum {IDLE,COLLECT,DECIDE,DONE}, clog2-based width functions.
// - Sub-module voting_cand_counter (clear, inc, CNT_W count), one per candidate via generate.
// - Top holds FSM, ballot counter, scan index, best-so-far registers.
// TESTING
// - C=1,V=4: start, ballots 1,1,0,1 -> auto-close; result_valid at t+2; cnt=3, ballots=4, majority=1, tie=0.
// - C=1,V=4: ballots 1,0,1,0 -> winner_cnt=2, majority=0, tie=1.
// - C=3,V=5: 001,010,010,100,001 -> counts 2,2,1; winner_idx=0, cnt=2, tie=1, majority=0; result_valid at t+4.
// - C=3,V=5: ballots 111,010 then close -> winner_idx=1, cnt=2, ballots=2, majority=1, tie=0; close at 0 ballots -> all-zero, tie=1.
// - Hold result_ready=0 10 cycles with start, ballot_valid pulsed -> outputs stable, ballot_ready=0, no new round.
// - rst mid-COLLECT after 2 ballots -> IDLE, all outputs 0; next round counts from zero.

Source files
------------

// File: rtl/voting_pkg.sv
// rtl/voting_pkg.sv - shared state encoding and width helpers for the ballot tallier
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE,
    DONE
  } state_e;

  function automatic int cnt_width(input int num_voters);
    return $clog2(num_voters + 1);
  endfunction

  function automatic int idx_width(input int num_cand);
    return (num_cand > 1) ? $clog2(num_cand) : 1;
  endfunction

endpackage

// File: rtl/voting_cand_counter.sv
// rtl/voting_cand_counter.sv - per-candidate vote counter with synchronous clear
module voting_cand_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/voting_tally_seq.sv
// rtl/voting_tally_seq.sv - streaming ballot tallier with sequential argmax decision
module voting_tally_seq
  import voting_pkg::*;
#(
  parameter  int NUM_CAND   = 1,
  parameter  int NUM_VOTERS = 4,
  localparam int CNT_W      = cnt_width(NUM_VOTERS),
  localparam int IDX_W      = idx_width(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ballot_valid,
  output logic                ballot_ready,
  input  logic [NUM_CAND-1:0] ballot,
  input  logic                close,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [IDX_W-1:0]    winner_idx,
  output logic [CNT_W-1:0]    winner_cnt,
  output logic [CNT_W-1:0]    ballots_cnt,
  output logic                majority,
  output logic                tie
);

  // Scan index runs one past the last candidate; that extra step latches the flags.
  localparam int SCAN_W = $clog2(NUM_CAND + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ballots_q, ballots_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
  logic              maj_q, maj_d;
  logic              tie_q, tie_d;

  logic [CNT_W-1:0]  cand_cnt [NUM_CAND];
  logic [CNT_W-1:0]  scan_cnt;
  logic [SCAN_W-1:0] n_at_best;
  logic              handshake;
  logic              clear_all;
  logic              maj_calc;
  logic              tie_calc;

  assign handshake = ballot_valid && (state_q == COLLECT);
  assign clear_all = start && (state_q == IDLE);

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
    voting_cand_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_all),
      .inc_i   (handshake && ballot[g]),
      .count_o (cand_cnt[g])
    );
  end

  always_comb begin
    scan_cnt  = '0;
    n_at_best = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        scan_cnt = cand_cnt[i];
      end
      if (cand_cnt[i] == best_cnt_q) begin
        n_at_best = n_at_best + SCAN_W'(1);
      end
    end
  end

  // Doubled winner count is compared one bit wider so it cannot wrap.
  assign maj_calc = {best_cnt_q, 1'b0} > {1'b0, ballots_q};
  assign tie_calc = (NUM_CAND > 1) ? (n_at_best > SCAN_W'(1))
                                   : ({best_cnt_q, 1'b0} == {1'b0, ballots_q});

  always_comb begin
    state_d    = state_q;
    ballots_d  = ballots_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    maj_d      = maj_q;
    tie_d      = tie_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          ballots_d = '0;
        end
      end
      COLLECT: begin
        if (handshake) begin
          ballots_d = ballots_q + CNT_W'(1);
        end
        if (close || (handshake && (ballots_q == CNT_W'(NUM_VOTERS - 1)))) begin
          state_d    = DECIDE;
          scan_d     = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
        end
      end
      DECIDE: begin
        if (scan_q == SCAN_W'(NUM_CAND)) begin
          maj_d   = maj_calc;
          tie_d   = tie_calc;
          state_d = DONE;
        end else begin
          // Strict compare keeps the lowest index on equal counts.
          if (scan_cnt > best_cnt_q) begin
            best_cnt_d = scan_cnt;
            best_idx_d = IDX_W'(scan_q);
          end
          scan_d = scan_q + SCAN_W'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ballots_q  <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      maj_q      <= 1'b0;
      tie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ballots_q  <= ballots_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      maj_q      <= maj_d;
      tie_q      <= tie_d;
    end
  end

  assign ballot_ready = (state_q == COLLECT);
  assign result_valid = (state_q == DONE);
  assign winner_idx   = best_idx_q;
  assign winner_cnt   = best_cnt_q;
  assign ballots_cnt  = ballots_q;
  assign majority     = maj_q;
  assign tie          = tie_q;

endmodule

// File: tb/tb_voting_tally_seq.sv
// tb/tb_voting_tally_seq.sv - randomized and directed checks of two tallier configurations
module tb_voting_tally_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, bv_a, close_a, rr_a, br_a, rv_a, maj_a, tie_a;
  logic [0:0] ballot_a, widx_a;
  logic [2:0] wcnt_a, bcnt_a;
  logic       start_b, bv_b, close_b, rr_b, br_b, rv_b, maj_b, tie_b;
  logic [2:0] ballot_b;
  logic [1:0] widx_b;
  logic [2:0] wcnt_b, bcnt_b;

  voting_tally_seq #(.NUM_CAND(1), .NUM_VOTERS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ballot_valid(bv_a), .ballot_ready(br_a),
    .ballot(ballot_a), .close(close_a), .result_valid(rv_a), .result_ready(rr_a),
    .winner_idx(widx_a), .winner_cnt(wcnt_a), .ballots_cnt(bcnt_a),
    .majority(maj_a), .tie(tie_a)
  );

  voting_tally_seq #(.NUM_CAND(3), .NUM_VOTERS(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ballot_valid(bv_b), .ballot_ready(br_b),
    .ballot(ballot_b), .close(close_b), .result_valid(rv_b), .result_ready(rr_b),
    .winner_idx(widx_b), .winner_cnt(wcnt_b), .ballots_cnt(bcnt_b),
    .majority(maj_b), .tie(tie_b)
  );

  int         cur = 0;
  int         ncand = 1;
  int         nvot = 4;
  int         total = 0;
  int         bad = 0;
  logic [2:0] bq[$];

  logic       o_br, o_rv, o_maj, o_tie;
  logic [1:0] o_idx;
  logic [2:0] o_wcnt, o_bcnt;

  always_comb begin
    if (cur == 0) begin
      o_br = br_a; o_rv = rv_a; o_maj = maj_a; o_tie = tie_a;
      o_idx = {1'b0, widx_a}; o_wcnt = wcnt_a; o_bcnt = bcnt_a;
    end else begin
      o_br = br_b; o_rv = rv_b; o_maj = maj_b; o_tie = tie_b;
      o_idx = widx_b; o_wcnt = wcnt_b; o_bcnt = bcnt_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int which);
    cur   = which;
    ncand = (which == 0) ? 1 : 3;
    nvot  = (which == 0) ? 4 : 5;
    #1;
  endtask

  task automatic drive(input logic st, input logic bv, input logic [2:0] b,
                       input logic cl, input logic rr);
    if (cur == 0) begin
      start_a = st; bv_a = bv; ballot_a = b[0]; close_a = cl; rr_a = rr;
    end else begin
      start_b = st; bv_b = bv; ballot_b = b; close_b = cl; rr_b = rr;
    end
  endtask

  // Reference tally of the ballots in bq: plain counting then first-maximum search.
  task automatic model(output int e_idx, output int e_cnt, output int e_nb,
                       output logic e_maj, output logic e_tie);
    int cnt[3];
    int nbest;
    cnt = '{0, 0, 0};
    foreach (bq[k]) begin
      for (int i = 0; i < ncand; i++) cnt[i] += int'(bq[k][i]);
    end
    e_idx = 0;
    e_cnt = cnt[0];
    for (int i = 1; i < ncand; i++) begin
      if (cnt[i] > e_cnt) begin
        e_idx = i;
        e_cnt = cnt[i];
      end
    end
    e_nb  = bq.size();
    e_maj = (2 * e_cnt > e_nb);
    nbest = 0;
    for (int i = 0; i < ncand; i++) if (cnt[i] == e_cnt) nbest++;
    e_tie = (ncand > 1) ? (nbest > 1) : (2 * e_cnt == e_nb);
  endtask

  task automatic run_round(input string name, input bit close_same, input bit gaps,
                           input bit release_it);
    int   lat;
    int   e_idx, e_cnt, e_nb;
    logic e_maj, e_tie;
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    total++;
    if (o_br !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_after_start: got %b want 1", name, o_br);
    end
    for (int k = 0; k < bq.size(); k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        drive(0, 0, 3'($urandom), 0, 0);
        step();
      end
      drive(0, 1, bq[k], (k == bq.size() - 1) && close_same && (bq.size() < nvot), 0);
      step();
    end
    if (bq.size() < nvot && !(close_same && bq.size() > 0)) begin
      drive(0, 0, 0, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    lat = 0;
    while (o_rv !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    total++;
    if (lat !== ncand + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, ncand + 1);
    end
    model(e_idx, e_cnt, e_nb, e_maj, e_tie);
    total++;
    if ({o_idx, o_wcnt, o_bcnt, o_maj, o_tie} !==
        {2'(e_idx), 3'(e_cnt), 3'(e_nb), e_maj, e_tie}) begin
      bad++;
      $display("FAIL %s result: got idx=%0d cnt=%0d nb=%0d maj=%b tie=%b want idx=%0d cnt=%0d nb=%0d maj=%b tie=%b",
               name, o_idx, o_wcnt, o_bcnt, o_maj, o_tie, e_idx, e_cnt, e_nb, e_maj, e_tie);
    end
    if (release_it) begin
      drive(0, 0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0, 0);
      total++;
      if (o_rv !== 1'b0 || o_br !== 1'b0) begin
        bad++;
        $display("FAIL %s release: got rv=%b br=%b want rv=0 br=0", name, o_rv, o_br);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      select(w);
      total++;
      if ({o_br, o_rv, o_idx, o_wcnt, o_bcnt, o_maj, o_tie} !== 12'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got br=%b rv=%b idx=%0d cnt=%0d nb=%0d maj=%b tie=%b want all 0",
                 w, o_br, o_rv, o_idx, o_wcnt, o_bcnt, o_maj, o_tie);
      end
    end
  endtask

  task automatic test_directed();
    select(0);
    bq = '{3'd1, 3'd1, 3'd0, 3'd1};
    run_round("ref_autoclose", 0, 0, 1);
    bq = '{3'd1, 3'd0, 3'd1, 3'd0};
    run_round("ref_even", 0, 0, 1);
    select(1);
    bq = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b001};
    run_round("cand_tie", 0, 0, 1);
    bq = '{3'b111, 3'b010};
    run_round("cand_close", 0, 0, 1);
    bq = '{3'b011, 3'b110};
    run_round("cand_close_same", 1, 0, 1);
    bq.delete();
    run_round("cand_empty", 0, 0, 1);
    select(0);
    bq.delete();
    run_round("ref_empty", 0, 0, 1);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 16; r++) begin
      select(r % 2);
      n = $urandom_range(0, nvot);
      bq.delete();
      for (int k = 0; k < n; k++) bq.push_back(3'($urandom) & 3'((1 << ncand) - 1));
      run_round($sformatf("rand%0d", r), bit'($urandom_range(0, 1)), 1, 1);
    end
  endtask

  task automatic test_hold();
    int   e_idx, e_cnt, e_nb;
    logic e_maj, e_tie;
    select(1);
    bq = '{3'b100, 3'b110, 3'b101};
    run_round("hold_setup", 0, 0, 0);
    model(e_idx, e_cnt, e_nb, e_maj, e_tie);
    for (int c = 0; c < 10; c++) begin
      drive(c[0], ~c[0], 3'($urandom), c[1], 0);
      step();
      total++;
      if ({o_rv, o_br, o_idx, o_wcnt, o_bcnt, o_maj, o_tie} !==
          {1'b1, 1'b0, 2'(e_idx), 3'(e_cnt), 3'(e_nb), e_maj, e_tie}) begin
        bad++;
        $display("FAIL hold cycle%0d: got rv=%b br=%b idx=%0d cnt=%0d nb=%0d want rv=1 br=0 idx=%0d cnt=%0d nb=%0d",
                 c, o_rv, o_br, o_idx, o_wcnt, o_bcnt, e_idx, e_cnt, e_nb);
      end
    end
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    total++;
    if (o_rv !== 1'b0 || o_br !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: got rv=%b br=%b want rv=0 br=0", o_rv, o_br);
    end
  endtask

  task automatic test_mid_reset();
    select(0);
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 1, 3'd1, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({o_br, o_rv, o_idx, o_wcnt, o_bcnt, o_maj, o_tie} !== 12'd0) begin
      bad++;
      $display("FAIL mid_reset: got br=%b rv=%b cnt=%0d nb=%0d maj=%b tie=%b want all 0",
               o_br, o_rv, o_wcnt, o_bcnt, o_maj, o_tie);
    end
    bq = '{3'd0, 3'd1};
    run_round("after_reset", 1, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 0; bv_a = 0; ballot_a = '0; close_a = 0; rr_a = 0;
    start_b = 0; bv_b = 0; ballot_b = '0; close_b = 0; rr_b = 0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
